// File: rtl/cmd_cntrl.sv
// rtl/cmd_cntrl.sv - station command controller: GO/STOP, barcode ID match, obstacle buzzer
// Optional buzzer counter/toggle enabled by defining CMD_CNTRL_BUZZER_EN; otherwise buzz=0, buzz_n=1.
module cmd_cntrl #(
   parameter int DEST_W    = 6,
   parameter int BUZZ_HALF = 6250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cmd,
   input  logic       cmd_rdy,
   output logic       clr_cmd_rdy,
   input  logic [7:0] ID,
   input  logic       ID_vld,
   output logic       clr_ID_vld,
   input  logic       OK2Move,
   output logic       go,
   output logic       in_transit,
   output logic       buzz,
   output logic       buzz_n
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] TRANSIT = 1'b1;

   localparam logic [1:0] OP_STOP = 2'b00;
   localparam logic [1:0] OP_GO   = 2'b01;

   logic [0:0]        state_q, state_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic [1:0]        opcode;
   logic              unused_ok;

   assign opcode    = cmd[7:6];
   assign unused_ok = &{1'b0, ID[7:6], (BUZZ_HALF > 0)};

   // A pending command always wins the cycle; a simultaneous ID waits one cycle.
   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      clr_cmd_rdy = cmd_rdy & rst_n;
      clr_ID_vld  = ID_vld & ~cmd_rdy & rst_n;
      if (cmd_rdy) begin
         case (opcode)
            OP_GO: begin
               dest_d  = cmd[DEST_W-1:0];
               state_d = TRANSIT;
            end
            OP_STOP: state_d = IDLE;
            default: ;
         endcase
      end else if (ID_vld && (state_q == TRANSIT) && (ID[DEST_W-1:0] == dest_q)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         dest_q  <= dest_d;
      end
   end

   assign in_transit = (state_q == TRANSIT);
   assign go         = in_transit & OK2Move;

`ifdef CMD_CNTRL_BUZZER_EN
   localparam int CNT_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             buzz_q, buzz_d;
   logic             buzz_active;

   assign buzz_active = in_transit & ~OK2Move;

   always_comb begin
      cnt_d  = '0;
      buzz_d = 1'b0;
      if (buzz_active) begin
         if (cnt_q == CNT_W'(BUZZ_HALF - 1)) begin
            cnt_d  = '0;
            buzz_d = ~buzz_q;
         end else begin
            cnt_d  = cnt_q + 1'b1;
            buzz_d = buzz_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         buzz_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         buzz_q <= buzz_d;
      end
   end

   assign buzz   = buzz_q;
   assign buzz_n = ~buzz_q;
`else
   assign buzz   = 1'b0;
   assign buzz_n = 1'b1;
`endif

endmodule
